// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between the integer execute
// path (requester 0) and the branch-compare path (requester 1).
// Each accepted request runs IDLE -> EXEC -> RESP, so the block issues one op
// every three cycles.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration.
// When the macro is undefined, requester 0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [SEL_W-1:0]  req_sel0,
    input  logic [SEL_W-1:0]  req_sel1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_branch,
    output logic              busy,
    output logic [DATA_W-1:0] alu_dataA,
    output logic [DATA_W-1:0] alu_dataB,
    output logic [SEL_W-1:0]  alu_selector,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_branch_taken
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [SEL_W-1:0]    op_sel;
    logic                owner;
    logic                last_grant;
    logic [DATA_W-1:0]   res_data;
    logic                res_branch;

    logic                grant;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [SEL_W-1:0]    sel_op;

    // Arbitration: pick which requester may be accepted this IDLE cycle
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            grant = ~last_grant;
`else
            // Fixed priority; last_grant is tracked but has no effect here
            grant = 1'b0 & last_grant;
`endif
        end
    end

    // Accept strobe: only the granted, valid requester, only in IDLE, never in reset
    always_comb begin
        req_ready = 2'b00;
        if (!rst && (state == IDLE) && req_valid[grant]) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Operand mux feeding the capture registers
    always_comb begin
        sel_a  = grant ? req_a1   : req_a0;
        sel_b  = grant ? req_b1   : req_b0;
        sel_op = grant ? req_sel1 : req_sel0;
    end

    // Control FSM, operand/result capture and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            res_data   <= '0;
            res_branch <= 1'b0;
            rsp_valid  <= 2'b00;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid[grant]) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        op_sel     <= sel_op;
                        owner      <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_data   <= alu_out;
                    res_branch <= alu_branch_taken;
                    rsp_valid  <= owner ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Register-driven datapath outputs
    assign rsp_data     = res_data;
    assign rsp_branch   = res_branch;
    assign alu_dataA    = op_a;
    assign alu_dataB    = op_b;
    assign alu_selector = op_sel;

endmodule
